game_state_ctrl: RTL and testbench

//  Top-level game sequencer for frogger_game. Owns the play state machine,

---
 rtl/game_state_ctrl_if.sv | 27 ++
 rtl/game_state_ctrl.sv | 151 +++++++++++++++
 tb/tb_game_state_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/game_state_ctrl_if.sv
// Purpose: signal bundle between the frogger game datapath and the game sequencer.
// Latency: none; this is wiring only.
// Backpressure: none; all signals are sampled levels every pixel clock.
interface game_state_ctrl_if;
  logic       i_Game_Start;    // start button level, debounced upstream
  logic       i_Draw_Frogger;  // frog pixel active this cycle
  logic       i_Draw_Car_Any;  // any car pixel active this cycle
  logic [5:0] i_Frogger_Y;     // frog tile row
  logic       o_Game_Active;   // high only while RUNNING
  logic       o_Frog_Reset;    // one-cycle pulse returning the frog to its start tile
  logic [6:0] o_Score;         // current score
  logic [1:0] o_Lives;         // remaining lives
  logic       o_Game_Over;     // high only while GAME_OVER
  logic [2:0] o_State;         // raw state code for debug / colour selection

  // Datapath side: drives the play inputs and observes sequencer status.
  modport master (
    output i_Game_Start, i_Draw_Frogger, i_Draw_Car_Any, i_Frogger_Y,
    input  o_Game_Active, o_Frog_Reset, o_Score, o_Lives, o_Game_Over, o_State
  );

  // Sequencer side.
  modport slave (
    input  i_Game_Start, i_Draw_Frogger, i_Draw_Car_Any, i_Frogger_Y,
    output o_Game_Active, o_Frog_Reset, o_Score, o_Lives, o_Game_Over, o_State
  );
endinterface

// File: rtl/game_state_ctrl.sv
// Purpose: frogger play sequencer - start/run/score/hit/cleanup/game-over, score and lives.
// Latency: state updates on the deciding edge; Game_Active/Game_Over follow the state one cycle later.
// Backpressure: none; every input is a per-cycle level and is simply ignored outside the states that use it.
module game_state_ctrl #(
  parameter int c_SCORE_LIMIT    = 99,
  parameter int c_LIVES          = 3,
  parameter int c_GOAL_ROW       = 0,
  parameter int c_CLEANUP_CYCLES = 25000000
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  game_state_ctrl_if.slave gs
);

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    RUNNING   = 3'b001,
    SCORED    = 3'b010,
    HIT       = 3'b011,
    CLEANUP   = 3'b100,
    GAME_OVER = 3'b101
  } state_t;

  // Counter is sized one bit generously so a cleanup length of 1 still yields a legal width.
  localparam int            CW          = $clog2(c_CLEANUP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(c_CLEANUP_CYCLES - 1);
  localparam logic [6:0]    SCORE_LIMIT = 7'(c_SCORE_LIMIT);
  localparam logic [1:0]    LIVES_INIT  = 2'(c_LIVES);
  localparam logic [5:0]    GOAL_ROW    = 6'(c_GOAL_ROW);

  state_t        r_State;
  logic          r_Start_d;
  logic [CW-1:0] r_Cleanup_Cnt;
  logic [6:0]    r_Score;
  logic [1:0]    r_Lives;
  logic          r_Game_Active;
  logic          r_Game_Over;
  logic          r_Frog_Reset;

  logic          w_Start;
  logic          w_Hit;
  logic          w_Goal;
  logic [6:0]    w_Score_Next;

  assign w_Start = gs.i_Game_Start & ~r_Start_d;
  assign w_Hit   = gs.i_Draw_Frogger & gs.i_Draw_Car_Any;
  assign w_Goal  = (gs.i_Frogger_Y == GOAL_ROW);

  // Score increment saturates so an out-of-range score can never wrap back to a low value.
  assign w_Score_Next = (r_Score >= SCORE_LIMIT) ? SCORE_LIMIT : (r_Score + 7'd1);

  // Remember the previous button level so a held button produces only one start event.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Start_d <= 1'b0;
    end else begin
      r_Start_d <= gs.i_Game_Start;
    end
  end

  // Play state machine together with score, lives, cleanup timer and all registered outputs.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State       <= IDLE;
      r_Cleanup_Cnt <= '0;
      r_Score       <= 7'd0;
      r_Lives       <= LIVES_INIT;
      r_Game_Active <= 1'b0;
      r_Game_Over   <= 1'b0;
      r_Frog_Reset  <= 1'b0;
    end else begin
      // Status flags trail the state register by one cycle.
      r_Game_Active <= (r_State == RUNNING);
      r_Game_Over   <= (r_State == GAME_OVER);
      r_Frog_Reset  <= 1'b0;

      case (r_State)
        IDLE: begin
          if (w_Start) begin
            r_State      <= RUNNING;
            r_Score      <= 7'd0;
            r_Lives      <= LIVES_INIT;
            r_Frog_Reset <= 1'b1;
          end
        end

        RUNNING: begin
          // A collision outranks reaching the goal row on the same cycle.
          if (w_Hit) begin
            r_State <= HIT;
          end else if (w_Goal) begin
            r_State <= SCORED;
          end
        end

        SCORED: begin
          r_Score <= w_Score_Next;
          if (w_Score_Next == SCORE_LIMIT) begin
            r_State <= GAME_OVER;
          end else begin
            r_State       <= CLEANUP;
            r_Cleanup_Cnt <= '0;
            r_Frog_Reset  <= 1'b1;
          end
        end

        HIT: begin
          // Last life (or an already-empty count) ends the game without wrapping.
          if (r_Lives <= 2'd1) begin
            r_Lives <= 2'd0;
            r_State <= GAME_OVER;
          end else begin
            r_Lives       <= r_Lives - 2'd1;
            r_State       <= CLEANUP;
            r_Cleanup_Cnt <= '0;
            r_Frog_Reset  <= 1'b1;
          end
        end

        CLEANUP: begin
          if (r_Cleanup_Cnt == CNT_LAST) begin
            r_Cleanup_Cnt <= '0;
            r_State       <= RUNNING;
          end else begin
            r_Cleanup_Cnt <= r_Cleanup_Cnt + 1'b1;
          end
        end

        GAME_OVER: begin
          // Only the edge leaves; the player must press again in IDLE to play.
          if (w_Start) begin
            r_State <= IDLE;
          end
        end

        default: begin
          r_State       <= IDLE;
          r_Cleanup_Cnt <= '0;
        end
      endcase
    end
  end

  assign gs.o_State       = r_State;
  assign gs.o_Score       = r_Score;
  assign gs.o_Lives       = r_Lives;
  assign gs.o_Game_Active = r_Game_Active;
  assign gs.o_Game_Over   = r_Game_Over;
  assign gs.o_Frog_Reset  = r_Frog_Reset;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Purpose: self-checking bench for game_state_ctrl (vector table, corner sequences, random vs model).
// Latency: outputs are compared 1 time unit after each rising clock edge.
// Backpressure: not applicable; inputs are driven every cycle.
module tb_game_state_ctrl;

  localparam int LIMIT = 3;
  localparam int LIVES = 3;
  localparam int GOAL  = 0;
  localparam int CLEAN = 8;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;

  game_state_ctrl_if gs();

  game_state_ctrl #(
    .c_SCORE_LIMIT   (LIMIT),
    .c_LIVES         (LIVES),
    .c_GOAL_ROW      (GOAL),
    .c_CLEANUP_CYCLES(CLEAN)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .gs   (gs)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference ----------------
  // Mode numbers are the visible o_State codes; cleanup is tracked as cycles remaining.
  int m_mode, m_score, m_lives, m_left;
  bit m_prev, m_active, m_over, m_frog;

  function automatic void model_reset();
    m_mode = 0; m_score = 0; m_lives = LIVES; m_left = 0;
    m_prev = 0; m_active = 0; m_over = 0; m_frog = 0;
  endfunction

  function automatic void model_step(bit st, bit df, bit dc, logic [5:0] y);
    bit press;
    press    = st && !m_prev;
    m_prev   = st;
    m_active = (m_mode == 1);
    m_over   = (m_mode == 5);
    m_frog   = 0;
    if (m_mode == 0) begin
      if (press) begin m_mode = 1; m_score = 0; m_lives = LIVES; m_frog = 1; end
    end else if (m_mode == 1) begin
      if (df && dc) m_mode = 3;
      else if (int'(y) == GOAL) m_mode = 2;
    end else if (m_mode == 2) begin
      m_score = (m_score + 1 > LIMIT) ? LIMIT : m_score + 1;
      if (m_score == LIMIT) m_mode = 5;
      else begin m_mode = 4; m_left = CLEAN; m_frog = 1; end
    end else if (m_mode == 3) begin
      if (m_lives <= 1) begin m_lives = 0; m_mode = 5; end
      else begin m_lives = m_lives - 1; m_mode = 4; m_left = CLEAN; m_frog = 1; end
    end else if (m_mode == 4) begin
      m_left = m_left - 1;
      if (m_left == 0) m_mode = 1;
    end else if (m_mode == 5) begin
      if (press) m_mode = 0;
    end else begin
      m_mode = 0;
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check_model(input string name);
    logic [14:0] got, exp;
    got = {gs.o_State, gs.o_Score, gs.o_Lives, gs.o_Game_Active, gs.o_Game_Over, gs.o_Frog_Reset};
    exp = {3'(m_mode), 7'(m_score), 2'(m_lives), m_active, m_over, m_frog};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d sc=%0d lv=%0d act=%0b ov=%0b fr=%0b, expected st=%0d sc=%0d lv=%0d act=%0b ov=%0b fr=%0b",
               name, got[14:12], got[11:5], got[4:3], got[2], got[1], got[0],
               exp[14:12], exp[11:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle for sampling.
  task automatic step(input bit st, input bit df, input bit dc, input logic [5:0] y);
    gs.i_Game_Start   = st;
    gs.i_Draw_Frogger = df;
    gs.i_Draw_Car_Any = dc;
    gs.i_Frogger_Y    = y;
    @(posedge clk);
    model_step(st, df, dc, y);
    #1;
  endtask

  task automatic run_until_running(input string name);
    for (int i = 0; i < 2 * CLEAN + 4 && m_mode != 1; i++) begin
      step(0, 0, 0, 6'd5);
      check_model(name);
    end
    check_val({name, " back in RUNNING"}, int'(gs.o_State), 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         st, df, dc;
    logic [5:0] y;
    int         e_state, e_score, e_lives;
    bit         e_act, e_over, e_frog;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit st, bit df, bit dc, logic [5:0] y,
                              int es, int esc, int el, bit ea, bit eo, bit ef);
    vec_t v;
    v.st = st; v.df = df; v.dc = dc; v.y = y;
    v.e_state = es; v.e_score = esc; v.e_lives = el;
    v.e_act = ea; v.e_over = eo; v.e_frog = ef;
    tbl.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [14:0] got, exp;

    // start, held start, goal, scored->cleanup with frog pulse
    add(1, 0, 0, 6'd5, 1, 0, 3, 0, 0, 1);
    add(1, 0, 0, 6'd5, 1, 0, 3, 1, 0, 0);
    add(0, 0, 0, 6'd0, 2, 0, 3, 1, 0, 0);
    add(0, 0, 0, 6'd5, 4, 1, 3, 0, 0, 1);
    // remaining seven cleanup cycles ignore hit/goal inputs
    for (int i = 0; i < CLEAN - 1; i++) add(0, 1, 1, 6'd0, 4, 1, 3, 0, 0, 0);
    add(0, 0, 0, 6'd5, 1, 1, 3, 0, 0, 0);
    // hit and goal together, with a start edge that RUNNING ignores: hit wins
    add(1, 1, 1, 6'd0, 3, 1, 3, 1, 0, 0);
    add(0, 0, 0, 6'd5, 4, 1, 2, 0, 0, 1);

    // reset state
    gs.i_Game_Start = 0; gs.i_Draw_Frogger = 0; gs.i_Draw_Car_Any = 0; gs.i_Frogger_Y = 6'd5;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset values");
    @(negedge clk);
    rst = 1'b0;

    // table-driven vectors
    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].df, tbl[i].dc, tbl[i].y);
      got = {gs.o_State, gs.o_Score, gs.o_Lives, gs.o_Game_Active, gs.o_Game_Over, gs.o_Frog_Reset};
      exp = {3'(tbl[i].e_state), 7'(tbl[i].e_score), 2'(tbl[i].e_lives),
             tbl[i].e_act, tbl[i].e_over, tbl[i].e_frog};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vector %0d: got st=%0d sc=%0d lv=%0d act=%0b ov=%0b fr=%0b, expected st=%0d sc=%0d lv=%0d act=%0b ov=%0b fr=%0b",
                 i, got[14:12], got[11:5], got[4:3], got[2], got[1], got[0],
                 exp[14:12], exp[11:5], exp[4:3], exp[2], exp[1], exp[0]);
      end
    end

    // three hits in total: lives run out, game over, restart needs a fresh edge
    run_until_running("hits wait");
    step(0, 1, 1, 6'd5); check_model("hit 2");
    step(0, 0, 0, 6'd5); check_model("hit 2 cleanup");
    check_val("lives after hit 2", int'(gs.o_Lives), 1);
    run_until_running("hits wait 2");
    step(0, 1, 1, 6'd5); check_model("hit 3");
    step(0, 0, 0, 6'd5);
    check_val("state after last life", int'(gs.o_State), 5);
    check_val("lives after last life", int'(gs.o_Lives), 0);
    step(0, 0, 0, 6'd5);
    check_val("game over flag", int'(gs.o_Game_Over), 1);
    check_val("game active in game over", int'(gs.o_Game_Active), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 6'd0);
      check_val("frozen lives", int'(gs.o_Lives), 0);
      check_val("frozen score", int'(gs.o_Score), 1);
    end
    step(1, 0, 0, 6'd5); check_val("start leaves game over", int'(gs.o_State), 0);
    step(1, 0, 0, 6'd5); check_model("held start stays idle");
    step(1, 0, 0, 6'd5); check_val("held start stays idle", int'(gs.o_State), 0);
    step(0, 0, 0, 6'd5); check_model("release in idle");
    step(1, 0, 0, 6'd5);
    check_val("second press runs", int'(gs.o_State), 1);
    check_val("lives reloaded", int'(gs.o_Lives), 3);
    check_val("score reloaded", int'(gs.o_Score), 0);
    check_val("restart frog pulse", int'(gs.o_Frog_Reset), 1);

    // three goals reach the score limit; further play inputs change nothing
    for (int g = 0; g < LIMIT; g++) begin
      run_until_running("goal wait");
      step(0, 0, 0, 6'(GOAL)); check_model("goal scored");
      step(0, 0, 0, 6'd5);     check_model("after goal");
    end
    check_val("state at score limit", int'(gs.o_State), 5);
    check_val("score at limit", int'(gs.o_Score), LIMIT);
    for (int i = 0; i < 3; i++) begin
      step(0, i[0], 1, 6'd0);
      check_val("score frozen at limit", int'(gs.o_Score), LIMIT);
      check_val("lives frozen at limit", int'(gs.o_Lives), 3);
    end
    step(1, 0, 0, 6'd5); check_model("limit start to idle");

    // asynchronous reset while the cleanup counter is at 4
    step(0, 0, 0, 6'd5); check_model("pre idle");
    step(1, 0, 0, 6'd5); check_model("start for reset test");
    step(0, 0, 0, 6'(GOAL)); check_model("goal for reset test");
    step(0, 0, 0, 6'd5);     check_model("cleanup entry");
    for (int i = 0; i < 4; i++) begin step(0, 0, 0, 6'd5); check_model("cleanup count"); end
    #1;
    rst = 1'b1;
    #1;
    check_val("async reset state", int'(gs.o_State), 0);
    check_val("async reset score", int'(gs.o_Score), 0);
    check_val("async reset lives", int'(gs.o_Lives), 3);
    check_val("async reset no frog pulse", int'(gs.o_Frog_Reset), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 6'd5); check_model("idle after reset");
    step(0, 1, 1, 6'd0); check_model("idle ignores play");

    // randomized play against the reference
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] y;
      y = ($urandom_range(0, 9) == 0) ? 6'(GOAL) : 6'($urandom_range(1, 63));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, y);
      check_model("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
